fft_dif_ctrl: RTL and testbench
===============================

Name: fft_dif_ctrl

Overview:
Address and twiddle sequencer for the radix-2 decimation-in-frequency FFT datapath. It walks all log2(N) stages and issues one butterfly descriptor per transfer. Each descriptor carries two operand addresses plus the twiddle index pair (k_up, n_down) that feeds the twiddle calculator. A start/busy/done handshake sits on the host side. A valid/ready handshake sits on the butterfly-unit side.

Parameters:
- LOG2N, 3, log2 of FFT size N; legal range 1..8 (N = 2..256).
- AW, LOG2N, address width of addr_a/addr_b.
- GAP, 2, idle cycles inserted between stages when FFT_CTRL_STAGE_GAP_EN is defined (butterfly/twiddle pipeline drain); legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a transform; honoured only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last butterfly transfer.
- bf_valid  out  1  descriptor on bf_* is valid.
- bf_ready  in  1  butterfly unit accepts the descriptor this cycle.
- bf_addr_a  out  AW  upper operand address.
- bf_addr_b  out  AW  lower operand address (addr_a + span).
- bf_k_up  out  8  twiddle numerator index k.
- bf_n_down  out  9  twiddle denominator, a power of two; 9 bits so that 256 is representable.
- bf_stage  out  4  current stage index, 0..LOG2N-1.
- stage_done  out  1  one-cycle pulse after the last transfer of each stage.

Behaviour:
- Reset (rst_n=0 at a clk edge): all outputs 0, FSM to IDLE, counters 0. Reset mid-transform aborts immediately; no done pulse.
- FSM states: IDLE, RUN, GAP, FIN.
- IDLE: on start=1, go to RUN. Set stage=0 and j=0. busy=1 and bf_valid=1 in the next cycle.
- RUN:
  - bf_valid=1.
  - A transfer occurs when bf_valid&&bf_ready.
  - bf_* outputs are registers and must hold stable while bf_valid&&!bf_ready.
  - On a transfer with j < N/2-1: j increments.
  - On a transfer with j = N/2-1: stage_done pulses next cycle and j resets to 0.
    - If stage < LOG2N-1: stage increments. Go to GAP if FFT_CTRL_STAGE_GAP_EN is defined, otherwise stay in RUN with no bubble.
    - If stage = LOG2N-1: go to FIN.
- GAP: bf_valid=0 for exactly GAP cycles, then RUN.
- FIN: done=1 and busy=0 for one cycle, then IDLE. The stage_done for the last stage coincides with done.
- start outside IDLE is ignored. start in the same cycle as FIN is also ignored; start is first accepted the cycle after return to IDLE.
- Descriptor arithmetic, with span = N >> (stage+1), pos = j mod span, grp = j / span:
  - addr_a = grp*2*span + pos
  - addr_b = addr_a + span
  - k_up = pos
  - n_down = 2*span
- Implement the descriptor arithmetic with shifts and masks only; no dividers. All values are unsigned and fit their widths with no wrap.
- Throughput: one descriptor per cycle while bf_ready=1. Total transfers = LOG2N*N/2.
- Latency: first descriptor is valid 1 cycle after start is sampled. done asserts 1 cycle after the final transfer.
- bf_ready is ignored when bf_valid=0.

Optional Feature:
- FFT_CTRL_STAGE_GAP_EN defined: GAP state is present. After every non-final stage, exactly GAP cycles with bf_valid=0 are inserted before the first descriptor of the next stage. busy stays 1 through the gap.
- Undefined: GAP state and its counter are not compiled. The last descriptor of stage s is followed directly by the first descriptor of stage s+1.

Test Plan:
- LOG2N=3, bf_ready tied 1, macro undefined, pulse start -> 12 consecutive descriptors (a,b,k,n):
  - stage 0: (0,4,0,8) (1,5,1,8) (2,6,2,8) (3,7,3,8)
  - stage 1: (0,2,0,4) (1,3,1,4) (4,6,0,4) (5,7,1,4)
  - stage 2: (0,1,0,2) (2,3,0,2) (4,5,0,2) (6,7,0,2)
  - done 1 cycle after the 12th transfer; stage_done at cycles 5, 9, 13 relative to start.
- Same config, bf_ready toggled pseudo-randomly -> identical 12-descriptor sequence; bf_* never changes while valid&&!ready.
- LOG2N=3, macro defined, GAP=2 -> exactly 2 bf_valid=0 cycles after the 4th and the 8th transfers; busy stays 1; total start-to-done = 17 cycles with ready=1.
- LOG2N=8 -> 1024 transfers. Stage 0 first descriptor is (0,128,0,256) and last is (127,255,127,256). Stage 7 last descriptor is (254,255,0,2).
- rst_n=0 for one cycle during stage 1 -> next cycle all outputs 0, state IDLE, no done. A fresh start then restarts from stage 0, j 0.
- start pulses during RUN and during FIN -> ignored. The sequence is unchanged and exactly one done is produced.

Source files
------------

// File: rtl/fft_dif_ctrl_if.sv
// Butterfly descriptor bus between the DIF FFT sequencer and the butterfly unit.
// Latency: none (wires only).
// Backpressure: bf_ready from the slave stalls the master; the descriptor holds while stalled.
//
// Ports (via modports):
//   master: drives bf_valid, bf_addr_a, bf_addr_b, bf_k_up, bf_n_down, bf_stage; samples bf_ready
//   slave : the mirror image
interface fft_dif_ctrl_if #(
    parameter int AW = 3
);
    logic          bf_valid;
    logic          bf_ready;
    logic [AW-1:0] bf_addr_a;
    logic [AW-1:0] bf_addr_b;
    logic [7:0]    bf_k_up;
    logic [8:0]    bf_n_down;
    logic [3:0]    bf_stage;

    modport master (
        output bf_valid,
        output bf_addr_a,
        output bf_addr_b,
        output bf_k_up,
        output bf_n_down,
        output bf_stage,
        input  bf_ready
    );

    modport slave (
        input  bf_valid,
        input  bf_addr_a,
        input  bf_addr_b,
        input  bf_k_up,
        input  bf_n_down,
        input  bf_stage,
        output bf_ready
    );
endinterface

// File: rtl/fft_dif_ctrl.sv
// Radix-2 DIF FFT address/twiddle sequencer: one butterfly descriptor per transfer over all stages.
// Latency: first descriptor valid 1 cycle after start; done 1 cycle after the last transfer.
// Backpressure: bf_ready low holds the registered descriptor stable; sequencing resumes on ready.
//
// Ports:
//   clk, rst_n        clock (rising edge) and synchronous active-low reset
//   start             one-cycle transform request, accepted only in IDLE
//   busy, done        host status; done is a one-cycle pulse, busy drops with it
//   stage_done        one-cycle pulse after the last transfer of each stage
//   bf (master)       descriptor bus: valid/ready, addr_a, addr_b, k_up, n_down, stage
//
// Build option: define FFT_CTRL_STAGE_GAP_EN to insert GAP idle cycles between stages
// (butterfly/twiddle pipeline drain). Without it stages run back to back.
module fft_dif_ctrl #(
    parameter int LOG2N = 3,
    parameter int AW    = LOG2N,
    parameter int GAP   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           stage_done,
    fft_dif_ctrl_if.master bf
);

    if (LOG2N < 1 || LOG2N > 8 || AW < LOG2N || GAP < 1 || GAP > 15) begin : g_bad_param
        $error("fft_dif_ctrl: parameter out of range");
    end

    localparam logic [3:0]    LAST_STAGE = 4'(LOG2N - 1);
    localparam logic [AW-1:0] HALF_M1    = AW'((1 << LOG2N) / 2 - 1);

    typedef struct packed {
        logic [AW-1:0] addr_a;
        logic [AW-1:0] addr_b;
        logic [7:0]    k_up;
        logic [8:0]    n_down;
    } desc_t;

`ifdef FFT_CTRL_STAGE_GAP_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_FIN} state_t;
    logic [3:0] gap_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
`endif

    state_t        state;
    logic [3:0]    stage_q;
    logic [AW-1:0] j_q;
    logic          valid_q;
    desc_t         desc_q;

    // span = N >> (stage+1) is a power of two, so j mod span is a mask and
    // j / span is a shift. addr_a has bit log2(span) clear, so adding span
    // is just setting that bit.
    function automatic desc_t desc_calc(input logic [3:0] stg, input logic [AW-1:0] jj);
        desc_t         d;
        logic [3:0]    sh;
        logic [AW-1:0] span;
        logic [AW-1:0] pos;
        logic [AW-1:0] grp;
        logic [AW-1:0] a;
        sh   = LAST_STAGE - stg;
        span = AW'(1) << sh;
        pos  = jj & (span - AW'(1));
        grp  = jj >> sh;
        a    = (grp << (sh + 4'd1)) | pos;
        d.addr_a = a;
        d.addr_b = a | span;
        d.k_up   = 8'(pos);
        d.n_down = 9'(span) << 1;
        return d;
    endfunction

    assign bf.bf_valid  = valid_q;
    assign bf.bf_addr_a = desc_q.addr_a;
    assign bf.bf_addr_b = desc_q.addr_b;
    assign bf.bf_k_up   = desc_q.k_up;
    assign bf.bf_n_down = desc_q.n_down;
    assign bf.bf_stage  = stage_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            stage_q    <= '0;
            j_q        <= '0;
            valid_q    <= 1'b0;
            desc_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            stage_done <= 1'b0;
`ifdef FFT_CTRL_STAGE_GAP_EN
            gap_cnt    <= '0;
`endif
        end else begin
            done       <= 1'b0;
            stage_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_RUN;
                        busy    <= 1'b1;
                        valid_q <= 1'b1;
                        stage_q <= '0;
                        j_q     <= '0;
                        desc_q  <= desc_calc(4'd0, '0);
                    end
                end

                // valid_q is always 1 here, so bf_ready alone marks a transfer
                S_RUN: begin
                    if (bf.bf_ready) begin
                        if (j_q != HALF_M1) begin
                            j_q    <= j_q + AW'(1);
                            desc_q <= desc_calc(stage_q, j_q + AW'(1));
                        end else begin
                            stage_done <= 1'b1;
                            j_q        <= '0;
                            if (stage_q != LAST_STAGE) begin
                                stage_q <= stage_q + 4'd1;
                                desc_q  <= desc_calc(stage_q + 4'd1, '0);
`ifdef FFT_CTRL_STAGE_GAP_EN
                                // next-stage descriptor is preloaded; it is released after the gap
                                valid_q <= 1'b0;
                                gap_cnt <= '0;
                                state   <= S_GAP;
`endif
                            end else begin
                                // last stage: stage_done and done land in the same cycle
                                valid_q <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                state   <= S_FIN;
                            end
                        end
                    end
                end

`ifdef FFT_CTRL_STAGE_GAP_EN
                S_GAP: begin
                    if (gap_cnt == 4'(GAP - 1)) begin
                        valid_q <= 1'b1;
                        state   <= S_RUN;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
`endif

                // start is deliberately not looked at here
                S_FIN: begin
                    state <= S_IDLE;
                end

                default: begin
                    state   <= S_IDLE;
                    valid_q <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_dif_ctrl.sv
// Directed bench for fft_dif_ctrl: an N=8 instance (descriptor table, backpressure,
// start noise, mid-transform reset) and an N=256 instance (full 1024-transfer sweep).
// Gap expectations follow FFT_CTRL_STAGE_GAP_EN with GAP=2.
module tb_fft_dif_ctrl;

`ifdef FFT_CTRL_STAGE_GAP_EN
    localparam int GAPC = 2;
`else
    localparam int GAPC = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start3, busy3, done3, sd3;
    logic start8, busy8, done8, sd8;

    fft_dif_ctrl_if #(.AW(3)) bf3();
    fft_dif_ctrl_if #(.AW(8)) bf8();

    fft_dif_ctrl #(.LOG2N(3), .AW(3), .GAP(2)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start3),
        .busy       (busy3),
        .done       (done3),
        .stage_done (sd3),
        .bf         (bf3)
    );

    fft_dif_ctrl #(.LOG2N(8), .AW(8), .GAP(2)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .busy       (busy8),
        .done       (done8),
        .stage_done (sd8),
        .bf         (bf8)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int exp_a [12] = '{0, 1, 2, 3, 0, 1, 4, 5, 0, 2, 4, 6};
    int exp_b [12] = '{4, 5, 6, 7, 2, 3, 6, 7, 1, 3, 5, 7};
    int exp_k [12] = '{0, 1, 2, 3, 0, 1, 0, 1, 0, 0, 0, 0};
    int exp_n [12] = '{8, 8, 8, 8, 4, 4, 4, 4, 2, 2, 2, 2};

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode 0: ready tied high; 1: random ready; 2: ready high plus start pulses in RUN and FIN
    task automatic run3(input int mode);
        int cyc = 0;
        int idx = 0;
        int sdn = 0;
        int donen = 0;
        int done_cyc = 0;
        int stab_err = 0;
        int busy_err = 0;
        int bubbles = 0;
        int post_err = 0;
        int xfer_cyc [12];
        int sd_cyc [3];
        logic prev_stall = 1'b0;
        int pa = 0, pb = 0, pk = 0, pn = 0, ps = 0;
        for (int i = 0; i < 12; i++) xfer_cyc[i] = 0;
        for (int i = 0; i < 3; i++) sd_cyc[i] = 0;
        start3 = 1'b1;
        bf3.bf_ready = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        cyc = 1;
        while (cyc < 400 && !(donen > 0 && cyc > done_cyc + 3)) begin
            bf3.bf_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            start3 = (mode == 2 && (cyc == 3 || done3 == 1'b1));
            if (prev_stall && (int'(bf3.bf_addr_a) != pa || int'(bf3.bf_addr_b) != pb ||
                               int'(bf3.bf_k_up) != pk || int'(bf3.bf_n_down) != pn ||
                               int'(bf3.bf_stage) != ps || !bf3.bf_valid))
                stab_err++;
            if (bf3.bf_valid && bf3.bf_ready) begin
                if (idx < 12) begin
                    check($sformatf("m%0d_d%0d_a", mode, idx), int'(bf3.bf_addr_a), exp_a[idx]);
                    check($sformatf("m%0d_d%0d_b", mode, idx), int'(bf3.bf_addr_b), exp_b[idx]);
                    check($sformatf("m%0d_d%0d_k", mode, idx), int'(bf3.bf_k_up), exp_k[idx]);
                    check($sformatf("m%0d_d%0d_n", mode, idx), int'(bf3.bf_n_down), exp_n[idx]);
                    check($sformatf("m%0d_d%0d_stage", mode, idx), int'(bf3.bf_stage), idx / 4);
                    xfer_cyc[idx] = cyc;
                end
                idx++;
            end
            if (sd3) begin
                if (sdn < 3) sd_cyc[sdn] = cyc;
                sdn++;
            end
            if (done3) begin
                if (donen == 0) done_cyc = cyc;
                donen++;
            end
            if (donen == 0) begin
                if (!busy3) busy_err++;
                if (!bf3.bf_valid) bubbles++;
            end else if (busy3 || bf3.bf_valid) begin
                post_err++;
            end
            prev_stall = bf3.bf_valid && !bf3.bf_ready;
            pa = int'(bf3.bf_addr_a);
            pb = int'(bf3.bf_addr_b);
            pk = int'(bf3.bf_k_up);
            pn = int'(bf3.bf_n_down);
            ps = int'(bf3.bf_stage);
            @(posedge clk); #1;
            cyc++;
        end
        start3 = 1'b0;
        check($sformatf("m%0d_done_count", mode), donen, 1);
        check($sformatf("m%0d_xfers", mode), idx, 12);
        check($sformatf("m%0d_done_lat", mode), done_cyc - xfer_cyc[11], 1);
        check($sformatf("m%0d_sd_count", mode), sdn, 3);
        for (int s = 0; s < 3; s++)
            check($sformatf("m%0d_sd%0d_after_xfer", mode, s), sd_cyc[s], xfer_cyc[4 * s + 3] + 1);
        check($sformatf("m%0d_busy_high", mode), busy_err, 0);
        check($sformatf("m%0d_gap_bubbles", mode), bubbles, 2 * GAPC);
        check($sformatf("m%0d_stall_stable", mode), stab_err, 0);
        check($sformatf("m%0d_idle_after_done", mode), post_err, 0);
        if (mode != 1) begin
            for (int s = 0; s < 3; s++)
                check($sformatf("m%0d_sd%0d_cycle", mode, s), sd_cyc[s], 5 + s * (4 + GAPC));
            check($sformatf("m%0d_done_cycle", mode), done_cyc, 13 + 2 * GAPC);
        end
    endtask

    task automatic reset_mid();
        int cyc = 0;
        int found = 0;
        int donen = 0;
        int active = 0;
        start3 = 1'b1;
        bf3.bf_ready = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        while (cyc < 50 && found == 0) begin
            if (bf3.bf_valid && bf3.bf_stage == 4'd1) begin
                found = 1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("rst_reach_stage1", found, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_busy", int'(busy3), 0);
        check("rst_done", int'(done3), 0);
        check("rst_stage_done", int'(sd3), 0);
        check("rst_valid", int'(bf3.bf_valid), 0);
        check("rst_addr_a", int'(bf3.bf_addr_a), 0);
        check("rst_addr_b", int'(bf3.bf_addr_b), 0);
        check("rst_k_up", int'(bf3.bf_k_up), 0);
        check("rst_n_down", int'(bf3.bf_n_down), 0);
        check("rst_stage", int'(bf3.bf_stage), 0);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (done3) donen++;
            if (busy3 || bf3.bf_valid) active++;
        end
        check("rst_no_done", donen, 0);
        check("rst_stays_idle", active, 0);
    endtask

    task automatic run8();
        int cyc = 0;
        int idx = 0;
        int bad = 0;
        int sdn = 0;
        int found_done = 0;
        int done_cyc = 0;
        int last = 0;
        int s, j, span, pos, grp, ea;
        start8 = 1'b1;
        bf8.bf_ready = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 1;
        while (cyc < 3000 && found_done == 0) begin
            if (sd8) sdn++;
            if (done8) begin
                found_done = 1;
                done_cyc = cyc;
            end else if (bf8.bf_valid && bf8.bf_ready) begin
                s    = idx / 128;
                j    = idx % 128;
                span = 256 >> (s + 1);
                pos  = j % span;
                grp  = j / span;
                ea   = grp * 2 * span + pos;
                if (int'(bf8.bf_addr_a) != ea || int'(bf8.bf_addr_b) != ea + span ||
                    int'(bf8.bf_k_up) != pos || int'(bf8.bf_n_down) != 2 * span ||
                    int'(bf8.bf_stage) != s)
                    bad++;
                if (idx == 0 || idx == 127 || idx == 1023) begin
                    check($sformatf("n256_d%0d_a", idx), int'(bf8.bf_addr_a),
                          (idx == 0) ? 0 : (idx == 127) ? 127 : 254);
                    check($sformatf("n256_d%0d_b", idx), int'(bf8.bf_addr_b),
                          (idx == 0) ? 128 : 255);
                    check($sformatf("n256_d%0d_k", idx), int'(bf8.bf_k_up),
                          (idx == 127) ? 127 : 0);
                    check($sformatf("n256_d%0d_n", idx), int'(bf8.bf_n_down),
                          (idx == 1023) ? 2 : 256);
                end
                idx++;
                last = cyc;
            end
            if (found_done == 0) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("n256_done_seen", found_done, 1);
        check("n256_xfers", idx, 1024);
        check("n256_model_mismatches", bad, 0);
        check("n256_done_lat", done_cyc - last, 1);
        check("n256_done_cycle", done_cyc, 1025 + 7 * GAPC);
        check("n256_stage_done_count", sdn, 8);
    endtask

    initial begin
        rst_n = 1'b0;
        start3 = 1'b0;
        start8 = 1'b0;
        bf3.bf_ready = 1'b0;
        bf8.bf_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("init_busy", int'(busy3), 0);
        check("init_done", int'(done3), 0);
        check("init_stage_done", int'(sd3), 0);
        check("init_valid", int'(bf3.bf_valid), 0);
        check("init_addr_a", int'(bf3.bf_addr_a), 0);
        check("init_addr_b", int'(bf3.bf_addr_b), 0);
        check("init_k_up", int'(bf3.bf_k_up), 0);
        check("init_n_down", int'(bf3.bf_n_down), 0);
        check("init_stage", int'(bf3.bf_stage), 0);
        check("init_busy8", int'(busy8), 0);
        check("init_valid8", int'(bf8.bf_valid), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run3(0);
        run3(1);
        run3(2);
        reset_mid();
        run3(0);
        run8();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
